branch_resolve_unit: RTL

//  ID-stage branch controller; consumes the 1-bit equality flag produced by the ID register comparator.

---
 rtl/branch_resolve_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// +----------------------------------------------------------------------------+
// | branch_resolve_unit: ID-stage BEQ/BNE hazard stall sequencing, resolution, |
// | comparator forward selects and saturating branch statistics. Rev 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module branch_resolve_unit #(
  parameter int REG_ADDR  = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 beq_id_i,
  input  logic                 bne_id_i,
  input  logic                 equal_i,
  input  logic [REG_ADDR-1:0]  rs_id_i,
  input  logic [REG_ADDR-1:0]  rt_id_i,
  input  logic                 reg_write_ex_i,
  input  logic                 mem_to_reg_ex_i,
  input  logic [REG_ADDR-1:0]  write_reg_ex_i,
  input  logic                 reg_write_mem_i,
  input  logic                 mem_to_reg_mem_i,
  input  logic [REG_ADDR-1:0]  write_reg_mem_i,
  output logic                 stall_o,
  output logic                 flush_id_ex_o,
  output logic                 pc_src_o,
  output logic                 flush_if_id_o,
  output logic                 fwd_a_id_o,
  output logic                 fwd_b_id_o,
  output logic [CNT_WIDTH-1:0] br_count_o,
  output logic [CNT_WIDTH-1:0] taken_count_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] br_count_q, br_count_d;
  logic [CNT_WIDTH-1:0] taken_count_q, taken_count_d;

  // Register 0 is hard-wired, so it can neither hazard nor be forwarded.
  function automatic logic reg_match(input logic [REG_ADDR-1:0] x,
                                     input logic [REG_ADDR-1:0] r);
    return (x == r) && (r != '0);
  endfunction

  logic w_br, w_hz_alu, w_hz_load, w_need2, w_hz, w_taken, w_resolve;

  assign w_br      = beq_id_i | bne_id_i;
  assign w_hz_alu  = reg_write_ex_i &
                     (reg_match(write_reg_ex_i, rs_id_i) | reg_match(write_reg_ex_i, rt_id_i));
  assign w_hz_load = reg_write_mem_i & mem_to_reg_mem_i &
                     (reg_match(write_reg_mem_i, rs_id_i) | reg_match(write_reg_mem_i, rt_id_i));
  assign w_need2   = w_hz_alu & mem_to_reg_ex_i;
  assign w_hz      = w_br & (w_hz_alu | w_hz_load);
  // BEQ wins when both decodes are (illegally) asserted.
  assign w_taken   = (beq_id_i & equal_i) | (bne_id_i & ~beq_id_i & ~equal_i);
  assign w_resolve = (state_q == IDLE) & w_br & ~w_hz;

  assign fwd_a_id_o = reg_write_mem_i & ~mem_to_reg_mem_i & reg_match(write_reg_mem_i, rs_id_i);
  assign fwd_b_id_o = reg_write_mem_i & ~mem_to_reg_mem_i & reg_match(write_reg_mem_i, rt_id_i);

  always_comb begin
    state_d       = state_q;
    stall_o       = 1'b0;
    flush_id_ex_o = 1'b0;
    pc_src_o      = 1'b0;
    flush_if_id_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (w_hz) begin
          stall_o       = 1'b1;
          flush_id_ex_o = 1'b1;
          state_d       = w_need2 ? HOLD : IDLE;
        end else if (w_br) begin
          pc_src_o      = w_taken;
          flush_if_id_o = w_taken;
        end
      end
      HOLD: begin
        // Second load-use bubble; the branch re-evaluates once back in IDLE.
        stall_o       = 1'b1;
        flush_id_ex_o = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    if (w_resolve) begin
      if (br_count_q != '1) br_count_d = br_count_q + CNT_WIDTH'(1);
      if (w_taken && (taken_count_q != '1)) taken_count_d = taken_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      state_q       <= state_d;
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign br_count_o    = br_count_q;
  assign taken_count_o = taken_count_q;

endmodule

`default_nettype wire
